// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode handshake and execute redirect.
// master = fetch_unit, slave = the surrounding memory/decode/execute logic.
interface fetch_unit_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        halt;

    modport master (
        output imem_addr, if_valid, if_instr, if_pc,
        input  imem_instr, id_ready, redirect_valid, redirect_target, halt
    );

    modport slave (
        input  imem_addr, if_valid, if_instr, if_pc,
        output imem_instr, id_ready, redirect_valid, redirect_target, halt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, absorbs the 1-cycle imem latency and queues
// returned {pc, instr} pairs in a 2-entry FIFO presented to decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    logic [15:0] pc_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_pc_q;
    logic [15:0] fifo_pc_q    [2];
    logic [15:0] fifo_instr_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  occ_q;

    logic        q_empty;
    logic        bypass;
    logic        if_valid;
    logic        pop;
    logic        push;
    logic        issue;
    logic        store_wr;
    logic        store_rd;
    logic [2:0]  pending;

    // With an empty queue the in-flight response is shown straight from imem,
    // giving the one-cycle issue-to-valid latency.
    assign q_empty  = (occ_q == 2'd0);
    assign bypass   = q_empty & rsp_valid_q;
    assign if_valid = ~q_empty | rsp_valid_q;

    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = if_valid;
    assign bus.if_instr  = bypass ? bus.imem_instr : fifo_instr_q[rd_ptr_q];
    assign bus.if_pc     = bypass ? rsp_pc_q       : fifo_pc_q[rd_ptr_q];

    assign pop     = if_valid & bus.id_ready;
    assign push    = rsp_valid_q & ~bus.redirect_valid;
    assign pending = {1'b0, occ_q} + {2'b00, rsp_valid_q} - {2'b00, pop};
    assign issue   = ~bus.halt & ~bus.redirect_valid & (pending < 3'd2);

    // A bypassed response that is accepted the same cycle never touches storage.
    assign store_wr = push & ~(bypass & pop);
    assign store_rd = pop & ~q_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= 16'h0000;
        end else if (bus.redirect_valid) begin
            pc_q        <= {bus.redirect_target[15:1], 1'b0};
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= issue;
            if (issue) begin
                rsp_pc_q <= pc_q;
                pc_q     <= pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            occ_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            occ_q    <= occ_q + {1'b0, store_wr} - {1'b0, store_rd};
            rd_ptr_q <= rd_ptr_q ^ store_rd;
            wr_ptr_q <= wr_ptr_q ^ store_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]    <= 16'h0000;
                fifo_instr_q[i] <= 16'h0000;
            end
        end else if (store_wr) begin
            fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
            fifo_instr_q[wr_ptr_q] <= bus.imem_instr;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, compared every
// cycle against a queue-level reference model of the fetch pipeline.
module tb_fetch_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if wbus ();

    fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master)
    );
    fetch_unit #(.RESET_PC(16'hFFFC), .PC_STEP(16'd2)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(wbus.master)
    );

    function automatic logic [15:0] memf(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h3011;
            16'h0002: return 16'h3112;
            16'h0004: return 16'h3212;
            default:  return {a[6:0], a[15:7]} ^ 16'hC3A5;
        endcase
    endfunction

    // synchronous-read instruction memories
    always @(posedge clk) begin
        bus.imem_instr  <= memf(bus.imem_addr);
        wbus.imem_instr <= memf(wbus.imem_addr);
    end

    int total = 0;
    int bad   = 0;
    int m_hs  = 0;
    int dut_hs = 0;

    logic [15:0] m_pc;
    logic        m_inf_v;
    logic [15:0] m_inf_pc;
    logic [15:0] mq[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = 16'h0000;
        m_inf_v  = 1'b0;
        m_inf_pc = 16'h0000;
        mq.delete();
    endtask

    function automatic logic m_valid();
        return (mq.size() > 0) || m_inf_v;
    endfunction

    function automatic logic [15:0] head_pc();
        if (mq.size() > 0) return mq[0];
        return m_inf_pc;
    endfunction

    // Visible order = queued entries followed by the in-flight fetch.
    task automatic model_update();
        logic [15:0] vis[$];
        logic        pop_m;
        logic        iss;
        vis = mq;
        if (m_inf_v) vis.push_back(m_inf_pc);
        pop_m = (vis.size() > 0) && bus.id_ready;
        if (pop_m) begin
            void'(vis.pop_front());
            m_hs++;
        end
        if (bus.redirect_valid) begin
            mq.delete();
            m_inf_v = 1'b0;
            m_pc    = {bus.redirect_target[15:1], 1'b0};
        end else begin
            iss     = !bus.halt && (vis.size() < 2);
            mq      = vis;
            m_inf_v = iss;
            if (iss) begin
                m_inf_pc = m_pc;
                m_pc     = m_pc + 16'd2;
            end
        end
    endtask

    task automatic check_outputs();
        chk1("if_valid", bus.if_valid, m_valid());
        if (m_valid()) begin
            chk("if_pc", bus.if_pc, head_pc());
            chk("if_instr", bus.if_instr, memf(head_pc()));
        end
        chk("imem_addr", bus.imem_addr, m_pc);
        chk1("no_overflow", dut.occ_q != 2'd3, 1'b1);
    endtask

    task automatic step();
        if (bus.if_valid && bus.id_ready) dut_hs++;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        bus.id_ready        = 1'b1;
        bus.halt            = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 16'h0000;
        wbus.id_ready        = 1'b1;
        wbus.halt            = 1'b0;
        wbus.redirect_valid  = 1'b0;
        wbus.redirect_target = 16'h0000;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_imem_addr", bus.imem_addr, 16'h0000);
        chk1("rst_if_valid", bus.if_valid, 1'b0);
        chk("rst_if_instr", bus.if_instr, 16'h0000);
        chk("rst_if_pc", bus.if_pc, 16'h0000);
        chk("rst_wrap_addr", wbus.imem_addr, 16'hFFFC);

        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // straight-line fetch on both instances
        step();
        chk("sl_pc0", bus.if_pc, 16'h0000);
        chk("sl_instr0", bus.if_instr, 16'h3011);
        chk("wrap_pc0", wbus.if_pc, 16'hFFFC);
        chk1("wrap_valid0", wbus.if_valid, 1'b1);
        step();
        chk("sl_pc2", bus.if_pc, 16'h0002);
        chk("sl_instr2", bus.if_instr, 16'h3112);
        chk("wrap_pc1", wbus.if_pc, 16'hFFFE);
        step();
        chk("sl_pc4", bus.if_pc, 16'h0004);
        chk("sl_instr4", bus.if_instr, 16'h3212);
        chk("wrap_pc2", wbus.if_pc, 16'h0000);
        chk("wrap_instr2", wbus.if_instr, memf(16'h0000));

        // backpressure then release
        bus.id_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("bp_occ_full", {14'd0, dut.occ_q}, 16'd2);
        bus.id_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // redirect with a full queue
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 16'h0009;
        step();
        bus.redirect_valid = 1'b0;
        chk1("redir_bubble", bus.if_valid, 1'b0);
        chk("redir_addr", bus.imem_addr, 16'h0008);
        step();
        chk1("redir_valid", bus.if_valid, 1'b1);
        chk("redir_pc", bus.if_pc, 16'h0008);
        bus.id_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // redirect in the same cycle as a pop and a landing response
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 16'h0100;
        step();
        bus.redirect_valid = 1'b0;
        chk1("sim_empty", bus.if_valid, 1'b0);
        step();
        chk("sim_pc", bus.if_pc, 16'h0100);
        chk("sim_hs", 16'(dut_hs), 16'(m_hs));

        // halt: drain, no new fetch, resume sequentially
        bus.halt = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk1("halt_idle", bus.if_valid, 1'b0);
        bus.halt = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.id_ready        = ($urandom_range(0, 3) != 0);
            bus.halt            = ($urandom_range(0, 9) == 0);
            bus.redirect_valid  = ($urandom_range(0, 19) == 0);
            bus.redirect_target = 16'($urandom);
            step();
        end
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;

        // asynchronous reset with a full queue
        bus.id_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mid_occ_full", {14'd0, dut.occ_q}, 16'd2);
        #2 rst_n = 1'b0;
        #1;
        chk1("mid_rst_valid", bus.if_valid, 1'b0);
        chk("mid_rst_addr", bus.imem_addr, 16'h0000);
        chk("mid_rst_occ", {14'd0, dut.occ_q}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bus.id_ready = 1'b1;
        step();
        chk("mid_restart_pc", bus.if_pc, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            bus.id_ready = ($urandom_range(0, 1) != 0);
            step();
        end
        chk("final_hs", 16'(dut_hs), 16'(m_hs));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
